// File: rtl/fm_tx_pkg.sv
// Shared definitions for the FM transmitter audio path.
//
// Contents:
//   I2S_DW_DEFAULT      - default audio word width delivered to the modulator
//   SYNC_STAGES_DEFAULT - default flop count per asynchronous input
//   rx_state_e          - I2S receiver framing state (HUNT / RUN)
//   CH_LEFT / CH_RIGHT  - word-select encodings of the two stereo channels
package fm_tx_pkg;

  localparam int I2S_DW_DEFAULT      = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } rx_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_oversampled_rx_sync_ff.sv
// sync_ff: N-stage single-bit synchronizer for bringing an asynchronous
// level into the clk domain.
//
// Parameters:
//   N    - number of flop stages (2 or more)
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears every stage to 0
//   d_i  - asynchronous input
//   q_o  - synchronized output (last stage)
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[N-2:0], d_i};
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/i2s_oversampled_rx.sv
// i2s_oversampled_rx: I2S receiver running entirely in the system clock
// domain. i2s_clk, i2s_ws and i2s_din are synchronized and oversampled; a
// rising edge of the synchronized bit clock is a bit event. Words are
// assembled MSB first and the selected channel is presented MSB-aligned on
// dout with a one-cycle dvalid pulse.
//
// Parameters:
//   DW          - output word width (extra bits dropped, short words padded)
//   SYNC_STAGES - flops per asynchronous input (2 or more)
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   i2s_clk  - asynchronous I2S bit clock
//   i2s_ws   - asynchronous word select (0 = left, 1 = right)
//   i2s_din  - asynchronous serial data, MSB first, one-bit delay after WS
//   chan_sel - channel to output (0 = left, 1 = right), quasi-static
//   dout     - last completed word of the selected channel
//   dvalid   - one-cycle pulse when dout updates
//
// Build option:
//   I2S_RX_UNSIGNED_EN - when defined, the dout MSB is inverted at the output
//                        register (two's complement -> offset binary).
module i2s_oversampled_rx
  import fm_tx_pkg::*;
#(
  parameter int DW          = I2S_DW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2s_clk,
  input  logic          i2s_ws,
  input  logic          i2s_din,
  input  logic          chan_sel,
  output logic [DW-1:0] dout,
  output logic          dvalid
);

  localparam int CW = $clog2(DW + 1);

  // ---------------------------------------------------------------------
  // Input synchronizers: bit 0 = sck, bit 1 = ws, bit 2 = din
  // ---------------------------------------------------------------------
  logic [2:0] async_in;
  logic [2:0] sync_out;

  assign async_in = {i2s_din, i2s_ws, i2s_clk};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_ff #(
      .N (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (async_in[gi]),
      .q_o (sync_out[gi])
    );
  end

  logic sck_s;
  logic ws_s;
  logic din_s;

  assign sck_s = sync_out[0];
  assign ws_s  = sync_out[1];
  assign din_s = sync_out[2];

  // ---------------------------------------------------------------------
  // Bit-event capture: ws/din are taken in the cycle the edge is seen and
  // held alongside the event flag so the framing logic sees one aligned set.
  // ---------------------------------------------------------------------
  logic sck_d_q;
  logic ev_q;
  logic ev_ws_q;
  logic ev_din_q;
  logic bit_evt;

  assign bit_evt = sck_s & ~sck_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_d_q  <= 1'b0;
      ev_q     <= 1'b0;
      ev_ws_q  <= 1'b0;
      ev_din_q <= 1'b0;
    end else begin
      sck_d_q  <= sck_s;
      ev_q     <= bit_evt;
      ev_ws_q  <= ws_s;
      ev_din_q <= din_s;
    end
  end

  // ---------------------------------------------------------------------
  // Framing state machine
  // ---------------------------------------------------------------------
  rx_state_e         state_q,    state_d;
  logic [CW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DW-1:0]     shreg_q,    shreg_d;
  logic              ws_last_q,  ws_last_d;
  logic [DW-1:0]     word_q,     word_d;
  logic              word_vld_q, word_vld_d;

  logic [DW-1:0]     shreg_wr;
  logic [CW-1:0]     cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ws_last_q  <= 1'b0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ws_last_q  <= ws_last_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  always_comb begin
    // Shift register with the current bit placed at DW-1-bit_cnt; once
    // bit_cnt reaches DW no position matches, so surplus bits are dropped.
    shreg_wr = shreg_q;
    for (int i = 0; i < DW; i++) begin
      if (bit_cnt_q == CW'(DW - 1 - i)) begin
        shreg_wr[i] = ev_din_q;
      end
    end
    cnt_inc = (bit_cnt_q == CW'(DW)) ? bit_cnt_q : bit_cnt_q + CW'(1);

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ws_last_d  = ws_last_q;
    word_d     = word_q;
    word_vld_d = 1'b0;

    case (state_q)
      HUNT: begin
        // Wait for a WS transition so the first word delivered is whole.
        if (ev_q) begin
          ws_last_d = ev_ws_q;
          if (ev_ws_q != ws_last_q) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (ev_q) begin
          if (ev_ws_q == ws_last_q) begin
            shreg_d   = shreg_wr;
            bit_cnt_d = cnt_inc;
          end else begin
            // The bit at the WS change still belongs to the previous word.
            if (ws_last_q == chan_sel) begin
              word_d     = shreg_wr;
              word_vld_d = 1'b1;
            end
            shreg_d   = '0;
            bit_cnt_d = '0;
            ws_last_d = ev_ws_q;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [DW-1:0] word_out;

`ifdef I2S_RX_UNSIGNED_EN
  assign word_out = {~word_q[DW-1], word_q[DW-2:0]};
`else
  assign word_out = word_q;
`endif

  logic [DW-1:0] dout_q;
  logic          dvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= word_vld_q;
      if (word_vld_q) begin
        dout_q <= word_out;
      end
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: tb/tb_i2s_oversampled_rx.sv
module tb_i2s_oversampled_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_clk = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_din = 1'b0;
  logic        chan_sel = 1'b0;
  logic [15:0] dout;
  logic        dvalid;

  i2s_oversampled_rx #(
    .DW          (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i2s_clk  (i2s_clk),
    .i2s_ws   (i2s_ws),
    .i2s_din  (i2s_din),
    .chan_sel (chan_sel),
    .dout     (dout),
    .dvalid   (dvalid)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] w;
    int          at;
  } exp_t;

  exp_t sb_q[$];

  // Channel periods of the current session: word, word length, slot length
  int p_w[$];
  int p_l[$];
  int p_s[$];

  task automatic add_per(input int w, input int l, input int s);
    p_w.push_back(w);
    p_l.push_back(l);
    p_s.push_back(s);
  endtask

  // Expected dout for a slot: the first 16 slot bits MSB-aligned, zero beyond
  function automatic logic [15:0] model(input int w, input int l, input int s);
    logic [15:0] r;
    logic [31:0] wv;
    r  = '0;
    wv = w;
    for (int j = 0; j < s && j < 16; j++) begin
      if (j < l) r[15 - j] = wv[l - 1 - j];
    end
`ifdef I2S_RX_UNSIGNED_EN
    r[15] = ~r[15];
`endif
    return r;
  endfunction

  // One I2S bit: 8 clk low (ws/din change), 8 clk high.
  // dvalid must appear 4 edges after the edge sampling sck high, i.e. 5
  // posedges after this negedge.
  task automatic drive_edge(input bit ws, input bit din, input bit push, input logic [15:0] e);
    exp_t x;
    @(negedge clk);
    i2s_clk = 1'b0;
    i2s_ws  = ws;
    i2s_din = din;
    repeat (8) @(negedge clk);
    i2s_clk = 1'b1;
    if (push) begin
      x.w  = e;
      x.at = cyc + 5;
      sb_q.push_back(x);
      $display("drive  exp=0x%04h due_cycle=%0d", e, x.at);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i2s_clk = 1'b0;
    i2s_ws  = 1'b0;
    i2s_din = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    rst = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dout", dout, 0);
    chk("midrst_dvalid", dvalid, 0);
    rst = 1'b0;
  endtask

  // Period 0 is discarded (HUNT) and the last period never completes; a
  // period ending with a reset is discarded as well.
  task automatic run_session(input bit cs, input int rst_per);
    int          np;
    bit          prev_bit;
    bit          push;
    bit          sbit;
    logic [15:0] e;
    logic [31:0] wv;
    do_reset();
    chan_sel = cs;
    np       = p_w.size();
    prev_bit = 1'b0;
    for (int p = 0; p < np; p++) begin
      wv = p_w[p];
      for (int j = 0; j < p_s[p]; j++) begin
        push = (j == 0) && (p >= 2) && ((p - 1) != rst_per) && (((p - 1) % 2) == int'(cs));
        e    = push ? model(p_w[p-1], p_l[p-1], p_s[p-1]) : 16'h0;
        drive_edge(p[0], prev_bit, push, e);
        sbit     = (j < p_l[p]) ? wv[p_l[p] - 1 - j] : 1'b0;
        prev_bit = sbit;
        if (p == rst_per && j == p_s[p] / 2) mid_reset();
      end
    end
    @(negedge clk);
    i2s_clk = 1'b0;
    repeat (40) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    p_w.delete();
    p_l.delete();
    p_s.delete();
  endtask

  // Monitor: every dvalid pops the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (dvalid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_dvalid", dout, 0);
          $display("recv   dout=0x%04h unexpected", dout);
        end else begin
          x = sb_q.pop_front();
          $display("recv   dout=0x%04h exp=0x%04h cycle=%0d due=%0d", dout, x.w, cyc, x.at);
          chk("dout", dout, x.w);
          chk("latency", cyc, x.at);
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Left-channel selection
    for (int p = 0; p < 9; p++) begin
      if (p % 2 == 0) add_per(32'h1234, 16, 32); else add_per(32'hABCD, 16, 32);
    end
    run_session(1'b0, -1);

    // Right-channel selection
    for (int p = 0; p < 9; p++) begin
      if (p % 2 == 0) add_per(32'h1234, 16, 32); else add_per(32'hABCD, 16, 32);
    end
    run_session(1'b1, -1);

    // Long word truncation
    for (int p = 0; p < 7; p++) begin
      if (p % 2 == 0) add_per(32'h89ABCD, 24, 32); else add_per(32'h123456, 24, 32);
    end
    run_session(1'b0, -1);

    // Short word padding (8-bit slots)
    for (int p = 0; p < 7; p++) begin
      if (p % 2 == 0) add_per(32'hA5, 8, 8); else add_per(32'h3C, 8, 8);
    end
    run_session(1'b0, -1);

    // Sign boundary words on the left channel
    for (int p = 0; p < 7; p++) begin
      if (p % 2 == 1)      add_per(32'h0001, 16, 32);
      else if (p % 4 == 2) add_per(32'h8000, 16, 32);
      else                 add_per(32'h7FFF, 16, 32);
    end
    run_session(1'b0, -1);

    // Reset in the middle of a left word
    for (int p = 0; p < 9; p++) begin
      if (p % 2 == 0) add_per(32'h5A5A, 16, 32); else add_per(32'h0F0F, 16, 32);
    end
    run_session(1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
